// File: rtl/evm_result_reader_pkg.sv
// Shared types and constants for the evm result reader: scan/send FSM
// encodings, candidate codes, frame geometry and the status byte layout.
package evm_result_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL0,
    ST_SEL1,
    ST_SEL2,
    ST_SEL_WIN,
    ST_SEND,
    ST_WAIT_REARM
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam logic [1:0] CAND_NONE = 2'b00;
  localparam logic [1:0] CAND_1    = 2'b01;
  localparam logic [1:0] CAND_2    = 2'b10;
  localparam logic [1:0] CAND_3    = 2'b11;

  localparam int FRAME_LEN = 6;

  // Status byte: tie flag on top, name mismatch below it, winner code at the bottom.
  function automatic logic [7:0] pack_status(input logic inv, input logic name_err,
                                             input logic [1:0] win);
    return {inv, name_err, 4'b0000, win};
  endfunction

endpackage

// File: rtl/evm_result_reader_if.sv
// Byte stream from the result reader to the display/telemetry sink.
// The master presents out_data/out_valid; the slave answers with out_ready.
interface evm_result_reader_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/evm_result_reader_frame_tx.sv
// Frame transmitter: latches the snapshot into a 6-byte frame on start,
// appends the XOR checksum, and walks it out over valid/ready.
module evm_result_reader_frame_tx
  import evm_result_reader_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 cnt0,
  input  logic [7:0]                 cnt1,
  input  logic [7:0]                 cnt2,
  input  logic [7:0]                 status,
  evm_result_reader_if.master        tx,
  output logic                       frame_end,
  output logic                       report_done
);

  logic [FRAME_LEN-1:0][7:0] frame;
  logic [2:0]                idx;
  logic                      accept;

  assign accept    = tx.out_valid && tx.out_ready;
  assign frame_end = accept && (idx == 3'(FRAME_LEN - 1));

  // Load the frame on start, then advance one byte per accepted handshake;
  // out_data only changes after an acceptance so it is stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame        <= '0;
      idx          <= '0;
      tx.out_data  <= '0;
      tx.out_valid <= 1'b0;
      report_done  <= 1'b0;
    end else begin
      report_done <= frame_end;
      if (start) begin
        frame        <= {cnt0 ^ cnt1 ^ cnt2 ^ status, status, cnt2, cnt1, cnt0, HEADER};
        idx          <= '0;
        tx.out_data  <= HEADER;
        tx.out_valid <= 1'b1;
      end else if (accept) begin
        if (frame_end) begin
          idx          <= '0;
          tx.out_data  <= '0;
          tx.out_valid <= 1'b0;
        end else begin
          idx         <= idx + 3'd1;
          tx.out_data <= frame[idx + 3'd1];
        end
      end
    end
  end

endmodule

// File: rtl/evm_result_reader.sv
// Results-side reader for the evm block: once voting is done it steps the evm
// display selects through the three tallies and the winner, snapshots them,
// and hands the snapshot to the frame transmitter. One frame per session.
module evm_result_reader
  import evm_result_reader_pkg::*;
#(
  parameter int         WIDTH         = 7,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] HEADER        = HEADER_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 voting_done,
  input  logic                 invalid_results,
  input  logic [1:0]           candidate_name,
  input  logic [WIDTH-1:0]     results,
  output logic [1:0]           display_results,
  output logic                 display_winner,
  evm_result_reader_if.master  out_if,
  output logic                 busy,
  output logic                 report_done
);

  state_t     state, next_state;
  logic [3:0] settle_cnt;
  logic       settle_last;
  logic       scan_state;
  logic       armed;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] win;
  logic       inv;
  logic       name_err;
  logic       tx_start;
  logic       frame_end;

  assign settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));
  assign scan_state  = (state == ST_SEL0) || (state == ST_SEL1) ||
                       (state == ST_SEL2) || (state == ST_SEL_WIN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next state: scan the selects in order, abort the scan if voting_done falls.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:       if (voting_done && armed) next_state = ST_SEL0;
      ST_SEL0:       if (!voting_done) next_state = ST_IDLE;
                     else if (settle_last) next_state = ST_SEL1;
      ST_SEL1:       if (!voting_done) next_state = ST_IDLE;
                     else if (settle_last) next_state = ST_SEL2;
      ST_SEL2:       if (!voting_done) next_state = ST_IDLE;
                     else if (settle_last) next_state = ST_SEL_WIN;
      ST_SEL_WIN:    if (!voting_done) next_state = ST_IDLE;
                     else if (settle_last) next_state = ST_SEND;
      ST_SEND:       if (frame_end) next_state = ST_WAIT_REARM;
      ST_WAIT_REARM: if (!voting_done) next_state = ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: evm selects and the busy flag.
  always_comb begin
    display_results = 2'b00;
    display_winner  = 1'b0;
    busy            = 1'b0;
    unique case (state)
      ST_SEL0:    busy = 1'b1;
      ST_SEL1:    begin display_results = 2'b01; busy = 1'b1; end
      ST_SEL2:    begin display_results = 2'b10; busy = 1'b1; end
      ST_SEL_WIN: begin display_winner = 1'b1; busy = 1'b1; end
      ST_SEND:    busy = 1'b1;
      default:    ;
    endcase
  end

  // Settle counter: restarts on every select change and on abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        settle_cnt <= '0;
    else if (scan_state && voting_done && !settle_last) settle_cnt <= settle_cnt + 4'd1;
    else                                             settle_cnt <= '0;
  end

  // One frame per session: disarm at scan start, rearm on abort or once voting_done drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        armed <= 1'b1;
    else if (state == ST_IDLE && next_state == ST_SEL0) armed <= 1'b0;
    else if ((scan_state || state == ST_WAIT_REARM) && !voting_done) armed <= 1'b1;
  end

  // Snapshot capture on the last settle cycle of each select, plus name checking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0     <= '0;
      cnt1     <= '0;
      cnt2     <= '0;
      win      <= CAND_NONE;
      inv      <= 1'b0;
      name_err <= 1'b0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= (state == ST_SEL_WIN) && voting_done && settle_last;
      if (state == ST_IDLE && next_state == ST_SEL0) name_err <= 1'b0;
      if (voting_done && settle_last) begin
        unique case (state)
          ST_SEL0: begin
            cnt0 <= 8'(results);
            if (!invalid_results && candidate_name != CAND_1) name_err <= 1'b1;
          end
          ST_SEL1: begin
            cnt1 <= 8'(results);
            if (!invalid_results && candidate_name != CAND_2) name_err <= 1'b1;
          end
          ST_SEL2: begin
            cnt2 <= 8'(results);
            if (!invalid_results && candidate_name != CAND_3) name_err <= 1'b1;
          end
          ST_SEL_WIN: begin
            win <= candidate_name;
            inv <= invalid_results;
          end
          default: ;
        endcase
      end
    end
  end

  evm_result_reader_frame_tx #(
    .HEADER (HEADER)
  ) u_frame_tx (
    .clk         (clk),
    .rst         (rst),
    .start       (tx_start),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .cnt2        (cnt2),
    .status      (pack_status(inv, name_err, win)),
    .tx          (out_if),
    .frame_end   (frame_end),
    .report_done (report_done)
  );

endmodule

// File: tb/tb_evm_result_reader.sv
// Directed bench for evm_result_reader: a small evm model answers the display
// selects, a vector table drives whole sessions, and hand-written sequences
// cover backpressure, abort, no-rearm and reset mid-frame.
module tb_evm_result_reader;
  import evm_result_reader_pkg::*;

  localparam int WIDTH  = 7;
  localparam int SETTLE = 2;
  localparam int LAT    = 4 * SETTLE + 2;

  typedef struct {
    logic [WIDTH-1:0] t0, t1, t2;
    logic [1:0]       win;
    logic             inv;
    logic             bad;
    logic [47:0]      exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             voting_done = 1'b0;
  logic             invalid_results;
  logic [1:0]       candidate_name;
  logic [WIDTH-1:0] results;
  logic [1:0]       display_results;
  logic             display_winner;
  logic             busy;
  logic             report_done;

  logic [WIDTH-1:0] m_t0 = '0, m_t1 = '0, m_t2 = '0;
  logic [1:0]       m_win = 2'b00;
  logic             m_inv = 1'b0;
  logic             m_bad = 1'b0;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int rd_seen = 0;

  vec_t vecs[6];

  evm_result_reader_if bus();

  evm_result_reader #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE),
    .HEADER        (8'hA5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .voting_done     (voting_done),
    .invalid_results (invalid_results),
    .candidate_name  (candidate_name),
    .results         (results),
    .display_results (display_results),
    .display_winner  (display_winner),
    .out_if          (bus),
    .busy            (busy),
    .report_done     (report_done)
  );

  always #5 clk = ~clk;

  // evm model: tally and name follow the selects; a tie reads back as zeros.
  always_comb begin
    results         = '0;
    invalid_results = m_inv;
    if (!m_inv) begin
      case (display_results)
        2'b00:   results = m_t0;
        2'b01:   results = m_t1;
        2'b10:   results = m_t2;
        default: results = '0;
      endcase
    end
    if (display_winner)      candidate_name = m_win;
    else if (m_inv || m_bad) candidate_name = 2'b00;
    else                     candidate_name = display_results + 2'd1;
  end

  // Monitor: running counts of valid cycles and report_done pulses.
  always @(negedge clk) begin
    if (bus.out_valid) valid_seen++;
    if (report_done)   rd_seen++;
  end

  function automatic vec_t mk(input logic [WIDTH-1:0] t0, t1, t2, input logic [1:0] win,
                              input logic inv, bad, input logic [47:0] exp);
    vec_t v;
    v.t0 = t0; v.t1 = t1; v.t2 = t2; v.win = win; v.inv = inv; v.bad = bad; v.exp = exp;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    m_t0 = v.t0; m_t1 = v.t1; m_t2 = v.t2;
    m_win = v.win; m_inv = v.inv; m_bad = v.bad;
    voting_done = 1'b1;
  endtask

  task automatic wait_valid(input string tag, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (cycles == 1) check_output({tag, "_busy_rise"}, 32'(busy), 32'd1);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic collect_frame(input string tag, input int stall_byte, input int stall_len,
                               output logic [47:0] got, output bit ok);
    int b = 0;
    int stall = 0;
    logic [7:0] held = '0;
    got = '0;
    ok = 1'b1;
    for (int n = 0; n < 100 && b < 6; n++) begin
      if (!bus.out_valid) begin
        check_output({tag, "_valid_dropped"}, 32'(b), 32'd6);
        ok = 1'b0;
        break;
      end
      if (b == stall_byte && stall < stall_len) begin
        bus.out_ready = 1'b0;
        if (stall == 0) held = bus.out_data;
        else            check_output({tag, "_stall_hold"}, 32'(bus.out_data), 32'(held));
        stall++;
      end else begin
        bus.out_ready = 1'b1;
        got[47 - 8*b -: 8] = bus.out_data;
        b++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    if (b != 6) ok = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag, input int stall_byte, input int stall_len);
    int cycles;
    bit ok;
    int rd_base;
    logic [47:0] got;
    rd_base = rd_seen;
    apply_stimulus(v);
    wait_valid(tag, cycles, ok);
    if (!ok) return;
    check_output({tag, "_latency"}, 32'(cycles), 32'(LAT));
    collect_frame(tag, stall_byte, stall_len, got, ok);
    for (int i = 0; i < 6; i++)
      check_output($sformatf("%s_byte%0d", tag, i), 32'(got[47 - 8*i -: 8]), 32'(v.exp[47 - 8*i -: 8]));
    if (!ok) return;
    check_output({tag, "_report_done"}, 32'(report_done), 32'd1);
    check_output({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_output({tag, "_valid_end"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check_output({tag, "_report_pulses"}, 32'(rd_seen - rd_base), 32'd1);
  endtask

  task automatic end_session();
    voting_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int vbase, rbase, cycles;
    bit ok;

    vecs[0] = mk(7'd5,   7'd3,   7'd2,   2'b01, 1'b0, 1'b0, 48'hA5_05_03_02_01_05);
    vecs[1] = mk(7'd0,   7'd0,   7'd0,   2'b00, 1'b1, 1'b0, 48'hA5_00_00_00_80_80);
    vecs[2] = mk(7'h7F,  7'h00,  7'h10,  2'b11, 1'b0, 1'b0, 48'hA5_7F_00_10_03_6C);
    vecs[3] = mk(7'd1,   7'd2,   7'd3,   2'b10, 1'b0, 1'b1, 48'hA5_01_02_03_42_42);
    vecs[4] = mk(7'd0,   7'd0,   7'd0,   2'b01, 1'b0, 1'b0, 48'hA5_00_00_00_01_01);
    vecs[5] = mk(7'h7F,  7'h7F,  7'h7F,  2'b11, 1'b0, 1'b0, 48'hA5_7F_7F_7F_03_7C);
    // Tie vector: evm tallies would be 4,4,1 but the model reads them back as zero.
    vecs[1].t0 = 7'd4; vecs[1].t1 = 7'd4; vecs[1].t2 = 7'd1;

    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_display_results", 32'(display_results), 32'd0);
    check_output("rst_display_winner",  32'(display_winner),  32'd0);
    check_output("rst_out_data",        32'(bus.out_data),    32'd0);
    check_output("rst_out_valid",       32'(bus.out_valid),   32'd0);
    check_output("rst_busy",            32'(busy),            32'd0);
    check_output("rst_report_done",     32'(report_done),     32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i), -1, 0);
      end_session();
    end

    $display("[TB] backpressure on byte 2");
    run_frame(vecs[0], "stall", 2, 11);
    end_session();

    $display("[TB] abort during SEL1");
    vbase = valid_seen;
    rbase = rd_seen;
    apply_stimulus(vecs[0]);
    repeat (SETTLE + 1) begin @(posedge clk); @(negedge clk); end
    check_output("abort_sel1_select", 32'(display_results), 32'd1);
    check_output("abort_sel1_busy",   32'(busy),            32'd1);
    voting_done = 1'b0;
    @(negedge clk);
    check_output("abort_busy_next", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check_output("abort_no_valid",  32'(valid_seen - vbase), 32'd0);
    check_output("abort_no_report", 32'(rd_seen - rbase),    32'd0);
    run_frame(vecs[2], "after_abort", -1, 0);
    end_session();

    $display("[TB] voting_done held high after frame");
    run_frame(vecs[0], "hold1", -1, 0);
    vbase = valid_seen;
    repeat (30) @(negedge clk);
    check_output("hold_no_second_frame", 32'(valid_seen - vbase), 32'd0);
    check_output("hold_busy",            32'(busy),               32'd0);
    end_session();
    run_frame(vecs[0], "hold2", -1, 0);
    end_session();

    $display("[TB] reset during byte 3");
    apply_stimulus(vecs[0]);
    wait_valid("rstmid", cycles, ok);
    if (ok) begin
      repeat (3) begin @(posedge clk); @(negedge clk); end
      check_output("rstmid_byte3_shown", 32'(bus.out_data), 32'h02);
      #1 rst = 1'b0;
      #1;
      check_output("rstmid_valid_async", 32'(bus.out_valid), 32'd0);
      check_output("rstmid_busy_async",  32'(busy),          32'd0);
      check_output("rstmid_data_async",  32'(bus.out_data),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_frame(vecs[0], "rstmid_rerun", -1, 0);
    end
    end_session();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
